sea_iter_core: RTL and testbench

- Iterative, parametrised SEA-style Feistel engine for encryption and decryption.
- Holds one block plus its key. Runs NR rounds at UNROLL rounds per clock through a shared round datapath built on the existing 3-bit sbox primitive.
- Uses a valid/ready handshake on both sides.
- Successor to the fixed 48-bit single-round combinational stage; sits between the block loader and the output formatter.

---
 rtl/sea_iter_core_if.sv | 26 ++
 rtl/sea_iter_core.sv | 162 ++++++++++++++++
 tb/tb_sea_iter_core.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sea_iter_core_if.sv
// rtl/sea_iter_core_if.sv - block/key input and result output handshake bundle for sea_iter_core
interface sea_iter_core_if #(
  parameter int HALF_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic [HALF_W-1:0] in_l;
  logic [HALF_W-1:0] in_r;
  logic [HALF_W-1:0] in_key;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_l;
  logic [HALF_W-1:0] out_r;
  logic              busy;

  modport master (
    output in_valid, mode, in_l, in_r, in_key, out_ready,
    input  in_ready, out_valid, out_l, out_r, busy
  );

  modport slave (
    input  in_valid, mode, in_l, in_r, in_key, out_ready,
    output in_ready, out_valid, out_l, out_r, busy
  );
endinterface

// File: rtl/sea_iter_core.sv
// rtl/sea_iter_core.sv - iterative SEA-style Feistel encrypt/decrypt engine, UNROLL rounds per clock
module sea_iter_core #(
  parameter int HALF_W = 48,
  parameter int WORD_W = 8,
  parameter int NR     = 48,
  parameter int UNROLL = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sea_iter_core_if.slave bus
);
  localparam int CW        = $clog2(NR + 1);
  localparam int NSLICE    = HALF_W / 3;
  localparam int DEC_SHIFT = (NR - 1) % HALF_W;
  localparam logic [CW-1:0] STEP = CW'(UNROLL);
  localparam logic [CW-1:0] LAST = CW'(NR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx, cnt_inc;
  logic [HALF_W-1:0] l_q, r_q, k_q;
  logic [HALF_W-1:0] l_nx, r_nx, k_nx;
  logic              mode_q, mode_nx;
  logic              armed;
  logic [HALF_W-1:0] l1, r1, k1, l2, r2, k2;

  function automatic logic [2:0] sbox(input logic [2:0] x);
    logic [2:0] y;
    case (x)
      3'd0:    y = 3'd0;
      3'd1:    y = 3'd5;
      3'd2:    y = 3'd6;
      3'd3:    y = 3'd7;
      3'd4:    y = 3'd4;
      3'd5:    y = 3'd3;
      3'd6:    y = 3'd1;
      default: y = 3'd2;
    endcase
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] f_fn(input logic [HALF_W-1:0] x, input logic [HALF_W-1:0] k);
    logic [HALF_W-1:0] m;
    logic [HALF_W-1:0] s;
    m = x ^ k;
    s = '0;
    for (int j = 0; j < NSLICE; j++) begin
      s[3*j +: 3] = sbox(m[3*j +: 3]);
    end
    return {s[HALF_W-2:0], s[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rot_r_word(input logic [HALF_W-1:0] x);
    return {x[WORD_W-1:0], x[HALF_W-1:WORD_W]};
  endfunction

  function automatic logic [HALF_W-1:0] rot_l_word(input logic [HALF_W-1:0] x);
    return {x[HALF_W-WORD_W-1:0], x[HALF_W-1:HALF_W-WORD_W]};
  endfunction

  function automatic logic [HALF_W-1:0] rotl1(input logic [HALF_W-1:0] x);
    return {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr1(input logic [HALF_W-1:0] x);
    return {x[0], x[HALF_W-1:1]};
  endfunction

  // Decrypt starts from the last round key; the shift is constant so this is pure wiring.
  function automatic logic [HALF_W-1:0] dec_start_key(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    y = '0;
    for (int b = 0; b < HALF_W; b++) begin
      y[(b + DEC_SHIFT) % HALF_W] = x[b];
    end
    return y;
  endfunction

  // Returns {l', r'}; the decrypt branch is the exact inverse of the encrypt branch.
  function automatic logic [2*HALF_W-1:0] round_fn(input logic dec, input logic [HALF_W-1:0] l,
                                                   input logic [HALF_W-1:0] r, input logic [HALF_W-1:0] k);
    logic [2*HALF_W-1:0] y;
    if (!dec) y = {r, f_fn(r, k) ^ rot_r_word(l)};
    else      y = {rot_l_word(r ^ f_fn(l, k)), l};
    return y;
  endfunction

  always_comb begin
    {l1, r1} = round_fn(mode_q, l_q, r_q, k_q);
    k1       = mode_q ? rotr1(k_q) : rotl1(k_q);
    if (UNROLL == 2) begin
      {l2, r2} = round_fn(mode_q, l1, r1, k1);
      k2       = mode_q ? rotr1(k1) : rotl1(k1);
    end else begin
      l2 = l1;
      r2 = r1;
      k2 = k1;
    end
  end

  assign cnt_inc = cnt + STEP;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    l_nx     = l_q;
    r_nx     = r_q;
    k_nx     = k_q;
    mode_nx  = mode_q;
    case (state)
      IDLE: begin
        if (bus.in_valid && armed) begin
          l_nx     = bus.in_l;
          r_nx     = bus.in_r;
          k_nx     = bus.mode ? dec_start_key(bus.in_key) : bus.in_key;
          mode_nx  = bus.mode;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        l_nx   = l2;
        r_nx   = r2;
        k_nx   = k2;
        cnt_nx = cnt_inc;
        if (cnt_inc == LAST) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      l_q    <= '0;
      r_q    <= '0;
      k_q    <= '0;
      mode_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      l_q    <= l_nx;
      r_q    <= r_nx;
      k_q    <= k_nx;
      mode_q <= mode_nx;
      armed  <= 1'b1;
    end
  end

  // armed keeps in_ready low until the first clock after reset release.
  assign bus.in_ready  = (state == IDLE) && armed;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_l     = l_q;
  assign bus.out_r     = r_q;
endmodule

// File: tb/tb_sea_iter_core.sv
// tb/tb_sea_iter_core.sv - scoreboard bench for sea_iter_core at 48/8/48/1 and 24/6/8/2
module tb_sea_iter_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sea_iter_core_if #(.HALF_W(48)) ia ();
  sea_iter_core_if #(.HALF_W(24)) ib ();

  sea_iter_core #(.HALF_W(48), .WORD_W(8), .NR(48), .UNROLL(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  sea_iter_core #(.HALF_W(24), .WORD_W(6), .NR(8),  .UNROLL(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  logic        in_valid_t [2];
  logic        mode_t     [2];
  logic        out_ready_t[2];
  logic [47:0] in_l_t     [2];
  logic [47:0] in_r_t     [2];
  logic [47:0] in_key_t   [2];
  logic        in_ready_o [2];
  logic        out_valid_o[2];
  logic        busy_o     [2];
  logic [47:0] out_l_o    [2];
  logic [47:0] out_r_o    [2];

  assign ia.in_valid  = in_valid_t[0];
  assign ia.mode      = mode_t[0];
  assign ia.out_ready = out_ready_t[0];
  assign ia.in_l      = in_l_t[0];
  assign ia.in_r      = in_r_t[0];
  assign ia.in_key    = in_key_t[0];
  assign ib.in_valid  = in_valid_t[1];
  assign ib.mode      = mode_t[1];
  assign ib.out_ready = out_ready_t[1];
  assign ib.in_l      = in_l_t[1][23:0];
  assign ib.in_r      = in_r_t[1][23:0];
  assign ib.in_key    = in_key_t[1][23:0];

  assign in_ready_o[0]  = ia.in_ready;
  assign out_valid_o[0] = ia.out_valid;
  assign busy_o[0]      = ia.busy;
  assign out_l_o[0]     = ia.out_l;
  assign out_r_o[0]     = ia.out_r;
  assign in_ready_o[1]  = ib.in_ready;
  assign out_valid_o[1] = ib.out_valid;
  assign busy_o[1]      = ib.busy;
  assign out_l_o[1]     = {24'b0, ib.out_l};
  assign out_r_o[1]     = {24'b0, ib.out_r};

  int total = 0;
  int bad = 0;
  logic [95:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int hw_of(input int w);  return (w == 0) ? 48 : 24; endfunction
  function automatic int ww_of(input int w);  return (w == 0) ? 8 : 6;   endfunction
  function automatic int nr_of(input int w);  return (w == 0) ? 48 : 8;  endfunction
  function automatic int lat_of(input int w); return (w == 0) ? 48 : 4;  endfunction

  function automatic logic [47:0] msk(input int hw);
    logic [47:0] one;
    one = 48'd1;
    return (hw == 48) ? {48{1'b1}} : ((one << hw) - 48'd1);
  endfunction

  function automatic logic [47:0] rnd(input int hw);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0] & msk(hw);
  endfunction

  function automatic logic [2:0] m_sbox(input logic [2:0] x);
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd3, 3'd1, 3'd2};
    return tbl[x];
  endfunction

  function automatic logic [47:0] m_rotl(input logic [47:0] x, input int n, input int hw);
    int s;
    s = n % hw;
    if (s == 0) return x & msk(hw);
    return ((x << s) | (x >> (hw - s))) & msk(hw);
  endfunction

  function automatic logic [47:0] m_f(input logic [47:0] x, input logic [47:0] k, input int hw);
    logic [47:0] m;
    logic [47:0] s;
    m = (x ^ k) & msk(hw);
    s = '0;
    for (int j = 0; j < hw / 3; j++) s[3*j +: 3] = m_sbox(m[3*j +: 3]);
    return m_rotl(s, 1, hw);
  endfunction

  // Reference cipher: round keys computed directly as rotl(K, i mod HALF_W).
  function automatic logic [95:0] m_cipher(input logic dec, input logic [47:0] l0, input logic [47:0] r0,
                                           input logic [47:0] k, input int w);
    logic [47:0] l, r, t, ki;
    int hw, ww;
    hw = hw_of(w);
    ww = ww_of(w);
    l = l0 & msk(hw);
    r = r0 & msk(hw);
    if (!dec) begin
      for (int i = 0; i < nr_of(w); i++) begin
        ki = m_rotl(k, i % hw, hw);
        t  = r;
        r  = m_f(r, ki, hw) ^ m_rotl(l, hw - ww, hw);
        l  = t;
      end
    end else begin
      for (int i = nr_of(w) - 1; i >= 0; i--) begin
        ki = m_rotl(k, i % hw, hw);
        t  = l;
        l  = m_rotl(r ^ m_f(l, ki, hw), ww, hw);
        r  = t;
      end
    end
    return {l, r};
  endfunction

  task automatic start_block(input int w, input logic m, input logic [47:0] l, input logic [47:0] r,
                             input logic [47:0] k);
    int n;
    @(negedge clk);
    in_valid_t[w] = 1'b1;
    mode_t[w]     = m;
    in_l_t[w]     = l;
    in_r_t[w]     = r;
    in_key_t[w]   = k;
    n = 0;
    while (!in_ready_o[w] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o[w]) check_eq("accept_timeout", 96'd0, 96'd1);
    @(posedge clk);
    #1;
    in_valid_t[w] = 1'b0;
  endtask

  task automatic finish_block(input int w, input bit toggle, input string tag);
    int n, bz;
    logic [95:0] exp;
    n  = 0;
    bz = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (busy_o[w]) bz++;
      if (out_valid_o[w]) break;
      if (toggle) begin
        mode_t[w]   = ~mode_t[w];
        in_key_t[w] = rnd(48);
      end
    end
    exp = sb_q.pop_front();
    if (!out_valid_o[w]) begin
      check_eq({tag, " timeout"}, 96'd0, 96'd1);
      return;
    end
    check_eq({tag, " data"}, {out_l_o[w], out_r_o[w]}, exp);
    check_eq({tag, " latency"}, 96'(n - 1), 96'(lat_of(w)));
    check_eq({tag, " busy"}, 96'(bz), 96'(lat_of(w) + 1));
    @(negedge clk);
    check_eq({tag, " idle"}, {93'd0, busy_o[w], out_valid_o[w], in_ready_o[w]}, 96'd1);
  endtask

  task automatic run_block(input int w, input logic m, input logic [47:0] l, input logic [47:0] r,
                           input logic [47:0] k, input bit toggle, input string tag);
    sb_q.push_back(m_cipher(m, l, r, k, w));
    start_block(w, m, l, r, k);
    finish_block(w, toggle, tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [47:0] l, r, k, hl, hr;
    logic [95:0] ct;
    int n;
    for (int w = 0; w < 2; w++) begin
      in_valid_t[w] = 1'b0; mode_t[w] = 1'b0; out_ready_t[w] = 1'b1;
      in_l_t[w] = '0; in_r_t[w] = '0; in_key_t[w] = '0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check_eq("reset outputs", {out_l_o[w], out_r_o[w]}, 96'd0);
      check_eq("reset flags", {93'd0, in_ready_o[w], out_valid_o[w], busy_o[w]}, 96'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready after reset", {95'd0, in_ready_o[0]}, 96'd1);

    run_block(0, 1'b0, 48'd0, 48'd0, 48'd0, 1'b0, "zero_enc");
    run_block(0, 1'b0, 48'h0123_4567_89ab, 48'hcdef_fedc_ba98, 48'h7654_3210_f0e1, 1'b0, "fixed_enc");
    run_block(0, 1'b1, 48'h0123_4567_89ab, 48'hcdef_fedc_ba98, 48'h7654_3210_f0e1, 1'b0, "fixed_dec");
    run_block(1, 1'b0, 48'h00ab_cdef, 48'h0012_3456, 48'h0089_abcd, 1'b0, "alt_enc");
    run_block(1, 1'b1, 48'h00ab_cdef, 48'h0012_3456, 48'h0089_abcd, 1'b0, "alt_dec");

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < ((w == 0) ? 120 : 200); i++) begin
        l = rnd(hw_of(w)); r = rnd(hw_of(w)); k = rnd(hw_of(w));
        ct = m_cipher(1'b0, l, r, k, w);
        run_block(w, 1'b0, l, r, k, 1'b0, "rt_enc");
        sb_q.push_back({l, r});
        start_block(w, 1'b1, ct[95:48], ct[47:0], k);
        finish_block(w, 1'b0, "rt_dec");
      end
    end

    for (int w = 0; w < 2; w++) begin
      l = rnd(hw_of(w)); r = rnd(hw_of(w)); k = rnd(hw_of(w));
      run_block(w, 1'b0, l, r, k, 1'b1, "toggle_enc");
      run_block(w, 1'b1, l, r, k, 1'b1, "toggle_dec");
    end

    l = rnd(48); r = rnd(48); k = rnd(48);
    sb_q.push_back(m_cipher(1'b0, l, r, k, 0));
    out_ready_t[0] = 1'b0;
    start_block(0, 1'b0, l, r, k);
    n = 0;
    while (!out_valid_o[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    hl = out_l_o[0];
    hr = out_r_o[0];
    check_eq("bp data", {hl, hr}, sb_q.pop_front());
    in_valid_t[0] = 1'b1;
    in_l_t[0] = ~l;
    repeat (10) begin
      @(negedge clk);
      check_eq("bp hold", {out_l_o[0], out_r_o[0]}, {hl, hr});
      check_eq("bp flags", {93'd0, out_valid_o[0], in_ready_o[0], busy_o[0]}, 96'd5);
    end
    out_ready_t[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_t[0] = 1'b0;
    @(negedge clk);
    check_eq("bp release", {93'd0, out_valid_o[0], in_ready_o[0], busy_o[0]}, 96'd2);

    l = rnd(48); r = rnd(48); k = rnd(48);
    start_block(0, 1'b0, l, r, k);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async rst data", {out_l_o[0], out_r_o[0]}, 96'd0);
    check_eq("async rst flags", {93'd0, out_valid_o[0], in_ready_o[0], busy_o[0]}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready after rst", {95'd0, in_ready_o[0]}, 96'd1);
    run_block(0, 1'b0, l, r, k, 1'b0, "post_rst_enc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
